number_to_word_ids: RTL and testbench

Converts a binary value 0–9999 into the ordered sequence of spoken-word IDs that the voice front end uses (1–9 ones, 10–20 and tens words, hundreds, thousands, 46 = DONE, 47 = START). It is the transmit direction of the word-ID accumulator path: it drives the text-to-speech / playback side, or loops back into the accumulator for self-test. Output is a valid/ready stream of 6-bit IDs, one word per beat, terminated by DONE.

---
 rtl/word_id_pkg.sv | 35 +++
 rtl/number_to_word_ids_if.sv | 9 +
 rtl/number_to_word_ids_bin2bcd_iter.sv | 55 +++++
 rtl/number_to_word_ids.sv | 131 +++++++++++++
 tb/tb_number_to_word_ids.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_id_pkg.sv
// Shared word-ID constants, FSM state type and BCD helper for the word-ID
// transmit and accumulator paths.
package word_id_pkg;

  localparam logic [5:0]  ID_DONE   = 6'd46;
  localparam logic [5:0]  ID_START  = 6'd47;
  localparam logic [5:0]  THOU_BASE = 6'd36;
  localparam logic [5:0]  HUND_BASE = 6'd27;
  localparam logic [5:0]  TENS_BASE = 6'd18;
  localparam logic [5:0]  ID_TEN    = 6'd10;
  localparam logic [5:0]  ID_TWENTY = 6'd20;
  localparam logic [13:0] MAX_VALUE = 14'd9999;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_EMIT_START,
    ST_EMIT_THOU,
    ST_EMIT_HUND,
    ST_EMIT_TENS,
    ST_EMIT_ONES,
    ST_EMIT_DONE
  } state_t;

  // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/number_to_word_ids_if.sv
// Word-ID stream: one 6-bit ID per beat, valid/ready handshake.
interface number_to_word_ids_if;
  logic [5:0] id;
  logic       id_valid;
  logic       id_ready;

  modport master (output id, output id_valid, input id_ready);
  modport slave  (input id, input id_valid, output id_ready);
endinterface

// File: rtl/number_to_word_ids_bin2bcd_iter.sv
// Iterative 14-bit binary to 4-digit BCD converter; done pulses one cycle
// after the 14th shift and the digits then hold until the next start.
module bin2bcd_iter
  import word_id_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [3:0]  thou,
  output logic [3:0]  hund,
  output logic [3:0]  tens,
  output logic [3:0]  ones
);

  logic [13:0] shift_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        running;
  logic [15:0] adj;

  assign adj = bcd_adjust(bcd_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      shift_q <= bin;
      bcd_q   <= '0;
      cnt_q   <= 4'd14;
      running <= 1'b1;
      done    <= 1'b0;
    end else if (running) begin
      {bcd_q, shift_q} <= {adj, shift_q} << 1;
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign thou = bcd_q[15:12];
  assign hund = bcd_q[11:8];
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/number_to_word_ids.sv
// Speaks a binary value 0-9999 as a stream of word IDs:
// [START], thousands, hundreds, tens/teens, ones, DONE.
module number_to_word_ids #(
  parameter bit EMIT_START = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [13:0]                 value,
  input  logic                        start,
  output logic                        busy,
  output logic                        err,
  number_to_word_ids_if.master        words
);
  import word_id_pkg::*;

  state_t     state;
  logic [5:0] id_q;
  logic       id_valid_q;
  logic       conv_start;
  logic       bcd_done;
  logic [3:0] thou, hund, tens, ones;

  assign conv_start = (state == ST_IDLE) && start && (value <= MAX_VALUE);

  bin2bcd_iter u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (value),
    .done  (bcd_done),
    .thou  (thou),
    .hund  (hund),
    .tens  (tens),
    .ones  (ones)
  );

  logic [5:0] thou_id, hund_id, tens_id, ones_id;
  logic [4:0] emit_mask;

  // Teens are a single word, so the ones digit is folded in when tens == 1.
  always_comb begin
    thou_id = THOU_BASE + {2'b00, thou};
    hund_id = HUND_BASE + {2'b00, hund};
    ones_id = {2'b00, ones};
    case (tens)
      4'd1:    tens_id = ID_TEN + {2'b00, ones};
      4'd2:    tens_id = ID_TWENTY;
      default: tens_id = TENS_BASE + {2'b00, tens};
    endcase
    emit_mask = {(ones != 4'd0) && (tens != 4'd1), tens != 4'd0,
                 hund != 4'd0, thou != 4'd0, EMIT_START};
  end

  logic [2:0] search_from;
  logic [2:0] nxt_pos;
  state_t     nxt_state;
  logic [5:0] nxt_id;

  // Next word is the first enabled slot after the current one; DONE always ends.
  always_comb begin
    case (state)
      ST_EMIT_START: search_from = 3'd1;
      ST_EMIT_THOU:  search_from = 3'd2;
      ST_EMIT_HUND:  search_from = 3'd3;
      ST_EMIT_TENS:  search_from = 3'd4;
      ST_EMIT_ONES:  search_from = 3'd5;
      default:       search_from = 3'd0;
    endcase
    nxt_pos = 3'd5;
    for (int k = 4; k >= 0; k--) begin
      if ((3'(k) >= search_from) && emit_mask[k]) nxt_pos = 3'(k);
    end
    case (nxt_pos)
      3'd0:    begin nxt_state = ST_EMIT_START; nxt_id = ID_START; end
      3'd1:    begin nxt_state = ST_EMIT_THOU;  nxt_id = thou_id;  end
      3'd2:    begin nxt_state = ST_EMIT_HUND;  nxt_id = hund_id;  end
      3'd3:    begin nxt_state = ST_EMIT_TENS;  nxt_id = tens_id;  end
      3'd4:    begin nxt_state = ST_EMIT_ONES;  nxt_id = ones_id;  end
      default: begin nxt_state = ST_EMIT_DONE;  nxt_id = ID_DONE;  end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      id_q       <= '0;
      id_valid_q <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (value > MAX_VALUE) begin
              err <= 1'b1;
            end else begin
              state <= ST_CONV;
              busy  <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          if (bcd_done) begin
            state      <= nxt_state;
            id_q       <= nxt_id;
            id_valid_q <= 1'b1;
          end
        end
        ST_EMIT_DONE: begin
          if (words.id_ready) begin
            state      <= ST_IDLE;
            id_q       <= '0;
            id_valid_q <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          if (words.id_ready) begin
            state <= nxt_state;
            id_q  <= nxt_id;
          end
        end
      endcase
    end
  end

  assign words.id       = id_q;
  assign words.id_valid = id_valid_q;

endmodule

// File: tb/tb_number_to_word_ids.sv
// Directed bench for number_to_word_ids: stream contents, latency,
// backpressure, range error, start-while-busy and mid-stream reset.
module tb_number_to_word_ids;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] value;
  logic        start;
  logic        busy;
  logic        err;

  number_to_word_ids_if words();

  number_to_word_ids #(.EMIT_START(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .start (start),
    .busy  (busy),
    .err   (err),
    .words (words)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int got_q[$];
  int stall_glitches;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count edges until the first word appears.
  task automatic launch(input logic [13:0] v, output logic busy_e0, output int latency);
    value = v;
    start = 1'b1;
    tick();
    start   = 1'b0;
    busy_e0 = busy;
    latency = 0;
    while (!words.id_valid && latency < 100) begin
      tick();
      latency++;
    end
  endtask

  // Consume n words; stall cycles of id_ready low before each beat.
  task automatic collect(input int n, input int stall, input int poke);
    int wait_c = 0;
    int guard  = 0;
    logic [5:0] held;
    logic hs;
    got_q.delete();
    stall_glitches = 0;
    while (got_q.size() < n && guard < 400) begin
      start = (guard == poke);
      if (guard == poke) value = 14'd42;
      words.id_ready = (wait_c >= stall);
      held = words.id;
      hs   = words.id_valid && words.id_ready;
      tick();
      guard++;
      if (hs) begin
        got_q.push_back(int'(held));
        wait_c = 0;
      end else begin
        wait_c++;
        if (!words.id_valid || words.id !== held) stall_glitches++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    value = '0;
    start = 1'b0;
    words.id_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if ({words.id, words.id_valid, busy, err} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got id=%0d v=%0d busy=%0d err=%0d expected all 0",
               words.id, words.id_valid, busy, err);
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_1234();
    int exp[6] = '{47, 37, 29, 21, 4, 46};
    logic b0;
    int lat;
    launch(14'd1234, b0, lat);
    vectors++;
    if (b0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_after_accept: got %0d expected 1", b0);
    end
    vectors++;
    if (lat !== 15) begin
      miscompares++;
      $display("[TB] FAIL first_word_latency: got %0d expected 15", lat);
    end
    collect(6, 0, -1);
    vectors++;
    if (got_q.size() !== 6) begin
      miscompares++;
      $display("[TB] FAIL 1234_count: got %0d expected 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL 1234_word%0d: got %0d expected %0d", i, got_q[i], exp[i]);
      end
    end
    vectors++;
    if (stall_glitches !== 0) begin
      miscompares++;
      $display("[TB] FAIL 1234_bubbles: got %0d expected 0", stall_glitches);
    end
    vectors++;
    if ({words.id_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL 1234_idle_after_done: got valid=%0d busy=%0d expected 0 0",
               words.id_valid, busy);
    end
  endtask

  task automatic test_teens_twenty();
    int vals[4] = '{2015, 1020, 9999, 0};
    int lens[4] = '{4, 4, 6, 2};
    int exp[4][6] = '{'{47, 38, 15, 46, 0, 0},
                      '{47, 37, 20, 46, 0, 0},
                      '{47, 45, 36, 27, 9, 46},
                      '{47, 46, 0, 0, 0, 0}};
    logic b0;
    int lat;
    for (int t = 0; t < 4; t++) begin
      launch(14'(vals[t]), b0, lat);
      collect(lens[t], 0, -1);
      vectors++;
      if (got_q.size() !== lens[t]) begin
        miscompares++;
        $display("[TB] FAIL %0d_count: got %0d expected %0d", vals[t], got_q.size(), lens[t]);
      end
      for (int i = 0; i < lens[t] && i < got_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp[t][i]) begin
          miscompares++;
          $display("[TB] FAIL %0d_word%0d: got %0d expected %0d", vals[t], i, got_q[i], exp[t][i]);
        end
      end
      vectors++;
      if (words.id_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %0d_end: got valid=%0d busy=%0d expected 0 0", vals[t], words.id_valid, busy);
      end
    end
  endtask

  task automatic test_range_error();
    int seen_valid = 0;
    value = 14'd10000;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({err, busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL err_pulse: got err=%0d busy=%0d expected 1 0", err, busy);
    end
    tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_width: got %0d expected 0", err);
    end
    for (int i = 0; i < 20; i++) begin
      if (words.id_valid || busy) seen_valid++;
      tick();
    end
    vectors++;
    if (seen_valid !== 0) begin
      miscompares++;
      $display("[TB] FAIL err_no_stream: got %0d active cycles expected 0", seen_valid);
    end
  endtask

  task automatic test_backpressure();
    int exp[4] = '{47, 32, 7, 46};
    logic b0;
    int lat;
    launch(14'd507, b0, lat);
    collect(4, 5, -1);
    vectors++;
    if (got_q.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL 507_count: got %0d expected 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL 507_word%0d: got %0d expected %0d", i, got_q[i], exp[i]);
      end
    end
    vectors++;
    if (stall_glitches !== 0) begin
      miscompares++;
      $display("[TB] FAIL 507_stall_stability: got %0d changes expected 0", stall_glitches);
    end
    vectors++;
    if (words.id_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL 507_end: got valid=%0d expected 0", words.id_valid);
    end
  endtask

  task automatic test_start_while_busy();
    int exp_a[6] = '{47, 37, 29, 21, 4, 46};
    int exp_b[4] = '{47, 22, 2, 46};
    logic b0;
    int lat;
    launch(14'd1234, b0, lat);
    collect(6, 0, 2);
    vectors++;
    if (got_q.size() !== 6) begin
      miscompares++;
      $display("[TB] FAIL busy_start_count: got %0d expected 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_a[i]) begin
        miscompares++;
        $display("[TB] FAIL busy_start_word%0d: got %0d expected %0d", i, got_q[i], exp_a[i]);
      end
    end
    tick();
    vectors++;
    if ({words.id_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL busy_start_no_requeue: got valid=%0d busy=%0d expected 0 0",
               words.id_valid, busy);
    end
    launch(14'd42, b0, lat);
    collect(4, 0, -1);
    vectors++;
    if (got_q.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL 42_count: got %0d expected 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_b[i]) begin
        miscompares++;
        $display("[TB] FAIL 42_word%0d: got %0d expected %0d", i, got_q[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    int exp[4] = '{47, 26, 8, 46};
    logic b0;
    int lat;
    launch(14'd1234, b0, lat);
    collect(2, 0, -1);
    vectors++;
    if (got_q.size() !== 2 || got_q[0] !== 47 || got_q[1] !== 37) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_words: got %0d words expected 47,37", got_q.size());
    end
    words.id_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({words.id, words.id_valid, busy, err} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs: got id=%0d v=%0d busy=%0d expected all 0",
               words.id, words.id_valid, busy);
    end
    #2 reset = 1'b0;
    tick();
    launch(14'd88, b0, lat);
    collect(4, 0, -1);
    vectors++;
    if (got_q.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL 88_count: got %0d expected 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL 88_word%0d: got %0d expected %0d", i, got_q[i], exp[i]);
      end
    end
  endtask

  initial begin
    $display("[TB] number_to_word_ids directed test");
    test_reset();
    test_basic_1234();
    test_teens_twenty();
    test_range_error();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
